// File: rtl/neuron_update_sequencer_pkg.sv
// rtl/neuron_update_sequencer_pkg.sv - shared constants and encodings for the neuron update sequencer
package neuron_update_sequencer_pkg;

    localparam int N      = 256;
    localparam int M      = 8;
    localparam int SYN_AW = 2 * M - 3;

    // Last neuron index of a sweep; the counter stops here and wraps only via DONE.
    localparam logic [M-1:0] CNT_LAST = M'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_SPI  = 2'd0,
        MODE_TREF = 2'd1,
        MODE_EVT  = 2'd2,
        MODE_VIRT = 2'd3
    } mode_t;

endpackage

// File: rtl/neuron_update_sequencer_if.sv
// rtl/neuron_update_sequencer_if.sv - requester handshakes (SPI, tref, AER event) of the sequencer
interface neuron_update_sequencer_if;
    import neuron_update_sequencer_pkg::*;

    logic         SPI_REQ;
    logic         SPI_WE;
    logic [M-1:0] SPI_ADDR;
    logic         SPI_ACK;
    logic         TREF_REQ;
    logic         TREF_ACK;
    logic         EVT_REQ;
    logic [M-1:0] EVT_ADDR;
    logic [4:0]   EVT_VIRT;
    logic         EVT_ACK;

    modport master (
        output SPI_REQ, SPI_WE, SPI_ADDR, TREF_REQ, EVT_REQ, EVT_ADDR, EVT_VIRT,
        input  SPI_ACK, TREF_ACK, EVT_ACK
    );

    modport slave (
        input  SPI_REQ, SPI_WE, SPI_ADDR, TREF_REQ, EVT_REQ, EVT_ADDR, EVT_VIRT,
        output SPI_ACK, TREF_ACK, EVT_ACK
    );

endinterface

// File: rtl/neuron_update_arbiter.sv
// rtl/neuron_update_arbiter.sv - fixed-priority SPI > TREF > EVT grant with activity gating
module neuron_update_arbiter
    import neuron_update_sequencer_pkg::*;
(
    input  logic       gate,
    input  logic       spi_req,
    input  logic       tref_req,
    input  logic       evt_req,
    input  logic [4:0] evt_virt,
    output logic       grant,
    output mode_t      grant_mode
);

    // Frozen network serves SPI only; running network serves tref then events, SPI waits.
    always_comb begin
        grant      = 1'b0;
        grant_mode = MODE_SPI;
        if (gate) begin
            if (spi_req) begin
                grant      = 1'b1;
                grant_mode = MODE_SPI;
            end
        end else if (tref_req) begin
            grant      = 1'b1;
            grant_mode = MODE_TREF;
        end else if (evt_req) begin
            grant      = 1'b1;
            grant_mode = (evt_virt != 5'd0) ? MODE_VIRT : MODE_EVT;
        end
    end

endmodule

// File: rtl/neuron_update_sequencer.sv
// rtl/neuron_update_sequencer.sv - read-modify-write sequencer for neuron memory and synapse array
module neuron_update_sequencer
    import neuron_update_sequencer_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_sync,
    input  logic              SPI_GATE_ACTIVITY_sync,
    neuron_update_sequencer_if.slave req_if,
    output logic              CTRL_NEURMEM_CS,
    output logic              CTRL_NEURMEM_WE,
    output logic [M-1:0]      CTRL_NEURMEM_ADDR,
    output logic              CTRL_NEUR_EVENT,
    output logic              CTRL_NEUR_TREF,
    output logic [4:0]        CTRL_NEUR_VIRTS,
    output logic              CTRL_SYNARRAY_CS,
    output logic [SYN_AW-1:0] CTRL_SYNARRAY_ADDR,
    output logic              CTRL_NEUR_BURST_END
);

    state_t       state, state_nx;
    mode_t        mode, mode_nx;
    logic [M-1:0] cnt, cnt_nx;
    logic [M-1:0] addr_lat, addr_lat_nx;
    logic [4:0]   virt_lat, virt_lat_nx;
    logic         spi_we_lat, spi_we_nx;

    logic         grant;
    mode_t        grant_mode;
    logic         served_req;
    logic         sweep;
    logic         sweep_nx;
    logic         mem_active_nx;

    logic              cs_nx, we_nx, ev_nx, tref_nx, syn_cs_nx, burst_nx;
    logic [M-1:0]      addr_nx;
    logic [4:0]        virts_nx;
    logic [SYN_AW-1:0] syn_addr_nx;
    logic              spi_ack_nx, tref_ack_nx, evt_ack_nx;
    logic              spi_ack_q, tref_ack_q, evt_ack_q;

    neuron_update_arbiter u_arb (
        .gate       (SPI_GATE_ACTIVITY_sync),
        .spi_req    (req_if.SPI_REQ),
        .tref_req   (req_if.TREF_REQ),
        .evt_req    (req_if.EVT_REQ),
        .evt_virt   (req_if.EVT_VIRT),
        .grant      (grant),
        .grant_mode (grant_mode)
    );

    assign sweep    = (mode == MODE_TREF) || (mode == MODE_EVT);
    assign sweep_nx = (mode_nx == MODE_TREF) || (mode_nx == MODE_EVT);

    assign served_req = (mode == MODE_SPI)  ? req_if.SPI_REQ  :
                        (mode == MODE_TREF) ? req_if.TREF_REQ : req_if.EVT_REQ;

    assign req_if.SPI_ACK  = spi_ack_q;
    assign req_if.TREF_ACK = tref_ack_q;
    assign req_if.EVT_ACK  = evt_ack_q;

    // State register: FSM, sweep counter, latched request fields and the registered outputs.
    always_ff @(posedge CLK) begin
        if (RST_sync) begin
            state               <= IDLE;
            mode                <= MODE_SPI;
            cnt                 <= '0;
            addr_lat            <= '0;
            virt_lat            <= '0;
            spi_we_lat          <= 1'b0;
            CTRL_NEURMEM_CS     <= 1'b0;
            CTRL_NEURMEM_WE     <= 1'b0;
            CTRL_NEURMEM_ADDR   <= '0;
            CTRL_NEUR_EVENT     <= 1'b0;
            CTRL_NEUR_TREF      <= 1'b0;
            CTRL_NEUR_VIRTS     <= '0;
            CTRL_SYNARRAY_CS    <= 1'b0;
            CTRL_SYNARRAY_ADDR  <= '0;
            CTRL_NEUR_BURST_END <= 1'b0;
            spi_ack_q           <= 1'b0;
            tref_ack_q          <= 1'b0;
            evt_ack_q           <= 1'b0;
        end else begin
            state               <= state_nx;
            mode                <= mode_nx;
            cnt                 <= cnt_nx;
            addr_lat            <= addr_lat_nx;
            virt_lat            <= virt_lat_nx;
            spi_we_lat          <= spi_we_nx;
            CTRL_NEURMEM_CS     <= cs_nx;
            CTRL_NEURMEM_WE     <= we_nx;
            CTRL_NEURMEM_ADDR   <= addr_nx;
            CTRL_NEUR_EVENT     <= ev_nx;
            CTRL_NEUR_TREF      <= tref_nx;
            CTRL_NEUR_VIRTS     <= virts_nx;
            CTRL_SYNARRAY_CS    <= syn_cs_nx;
            CTRL_SYNARRAY_ADDR  <= syn_addr_nx;
            CTRL_NEUR_BURST_END <= burst_nx;
            spi_ack_q           <= spi_ack_nx;
            tref_ack_q          <= tref_ack_nx;
            evt_ack_q           <= evt_ack_nx;
        end
    end

    // Next state: grant only from IDLE, RD/WR pairs per neuron, DONE holds until the request drops.
    always_comb begin
        state_nx    = state;
        mode_nx     = mode;
        cnt_nx      = cnt;
        addr_lat_nx = addr_lat;
        virt_lat_nx = virt_lat;
        spi_we_nx   = spi_we_lat;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nx = RD;
                    mode_nx  = grant_mode;
                    cnt_nx   = '0;
                    if (grant_mode == MODE_SPI) begin
                        addr_lat_nx = req_if.SPI_ADDR;
                        spi_we_nx   = req_if.SPI_WE;
                    end else if (grant_mode != MODE_TREF) begin
                        addr_lat_nx = req_if.EVT_ADDR;
                        virt_lat_nx = req_if.EVT_VIRT;
                    end
                end
            end
            RD: begin
                // An SPI read needs no write-back; the memory output holds once CS drops.
                if ((mode == MODE_SPI) && !spi_we_lat) begin
                    state_nx = DONE;
                end else begin
                    state_nx = WR;
                end
            end
            WR: begin
                if (sweep && (cnt != CNT_LAST)) begin
                    cnt_nx   = cnt + M'(1);
                    state_nx = RD;
                end else begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (!served_req) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output decode from the next state, so the registered outputs line up with the state they describe.
    always_comb begin
        mem_active_nx = (state_nx == RD) || (state_nx == WR);
        cs_nx         = mem_active_nx;
        we_nx         = (state_nx == WR);
        addr_nx       = '0;
        if (mem_active_nx) begin
            addr_nx = sweep_nx ? cnt_nx : addr_lat_nx;
        end
        ev_nx       = mem_active_nx && ((mode_nx == MODE_EVT) || (mode_nx == MODE_VIRT));
        tref_nx     = mem_active_nx && (mode_nx == MODE_TREF);
        virts_nx    = ((mode_nx == MODE_VIRT) && (state_nx != IDLE)) ? virt_lat_nx : 5'd0;
        // Synapse word is read alongside the neuron read so both arrive in the WR cycle.
        syn_cs_nx   = (state_nx == RD) && (mode_nx == MODE_EVT);
        syn_addr_nx = syn_cs_nx ? {addr_lat_nx, cnt_nx[M-1:3]} : '0;
        burst_nx    = (state_nx == DONE) && (state != DONE) && (mode_nx != MODE_SPI);
        spi_ack_nx  = (state_nx == DONE) && (mode_nx == MODE_SPI);
        tref_ack_nx = (state_nx == DONE) && (mode_nx == MODE_TREF);
        evt_ack_nx  = (state_nx == DONE) && ((mode_nx == MODE_EVT) || (mode_nx == MODE_VIRT));
    end

endmodule

// File: tb/tb_neuron_update_sequencer.sv
// tb/tb_neuron_update_sequencer.sv - self-checking bench for neuron_update_sequencer
module tb_neuron_update_sequencer;

    localparam int NN      = 256;
    localparam int MD_SPI  = 0;
    localparam int MD_TREF = 1;
    localparam int MD_EVT  = 2;
    localparam int MD_VIRT = 3;

    logic        CLK;
    logic        RST_sync;
    logic        SPI_GATE_ACTIVITY_sync;
    logic        CTRL_NEURMEM_CS;
    logic        CTRL_NEURMEM_WE;
    logic [7:0]  CTRL_NEURMEM_ADDR;
    logic        CTRL_NEUR_EVENT;
    logic        CTRL_NEUR_TREF;
    logic [4:0]  CTRL_NEUR_VIRTS;
    logic        CTRL_SYNARRAY_CS;
    logic [12:0] CTRL_SYNARRAY_ADDR;
    logic        CTRL_NEUR_BURST_END;

    int checks;
    int failures;

    neuron_update_sequencer_if bus ();

    neuron_update_sequencer dut (
        .CLK                    (CLK),
        .RST_sync               (RST_sync),
        .SPI_GATE_ACTIVITY_sync (SPI_GATE_ACTIVITY_sync),
        .req_if                 (bus),
        .CTRL_NEURMEM_CS        (CTRL_NEURMEM_CS),
        .CTRL_NEURMEM_WE        (CTRL_NEURMEM_WE),
        .CTRL_NEURMEM_ADDR      (CTRL_NEURMEM_ADDR),
        .CTRL_NEUR_EVENT        (CTRL_NEUR_EVENT),
        .CTRL_NEUR_TREF         (CTRL_NEUR_TREF),
        .CTRL_NEUR_VIRTS        (CTRL_NEUR_VIRTS),
        .CTRL_SYNARRAY_CS       (CTRL_SYNARRAY_CS),
        .CTRL_SYNARRAY_ADDR     (CTRL_SYNARRAY_ADDR),
        .CTRL_NEUR_BURST_END    (CTRL_NEUR_BURST_END)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [34:0] obs;
    assign obs = {CTRL_NEURMEM_CS, CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR, CTRL_NEUR_EVENT,
                  CTRL_NEUR_TREF, CTRL_NEUR_VIRTS, CTRL_SYNARRAY_CS, CTRL_SYNARRAY_ADDR,
                  CTRL_NEUR_BURST_END, bus.SPI_ACK, bus.TREF_ACK, bus.EVT_ACK};

    function automatic logic [34:0] mk(input logic cs, input logic we, input logic [7:0] ad,
                                       input logic ev, input logic tr, input logic [4:0] vs,
                                       input logic sc, input logic [12:0] sa, input logic be,
                                       input logic ak_s, input logic ak_t, input logic ak_e);
        return {cs, we, ad, ev, tr, vs, sc, sa, be, ak_s, ak_t, ak_e};
    endfunction

    task automatic chk(input string tag, input logic [34:0] e);
        checks++;
        assert (obs === e)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic idle_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            chk(tag, '0);
        end
    endtask

    // Reference: one operation seen from its first RD cycle, through DONE, ack hold, and release.
    // abort_after >= 0 stops after that many memory cycles (used for the mid-sweep reset).
    task automatic expect_op(input int md, input logic [7:0] a, input logic [4:0] v, input logic spi_we,
                             input int hold, input int abort_after, input string tag);
        int          nmem;
        int          nid;
        logic        is_sweep;
        logic        rd;
        logic        is_ev;
        logic        syn;
        logic [7:0]  ad;
        logic [4:0]  vs;
        logic [12:0] sa;
        is_sweep = (md == MD_TREF) || (md == MD_EVT);
        is_ev    = (md == MD_EVT) || (md == MD_VIRT);
        vs       = (md == MD_VIRT) ? v : 5'd0;
        if (is_sweep)                      nmem = 2 * NN;
        else if (md == MD_SPI && !spi_we)  nmem = 1;
        else                               nmem = 2;
        for (int k = 0; k < nmem; k++) begin
            if (abort_after >= 0 && k >= abort_after) return;
            @(negedge CLK);
            nid = is_sweep ? k / 2 : int'(a);
            rd  = (k % 2) == 0;
            ad  = 8'(nid);
            syn = (md == MD_EVT) && rd;
            sa  = syn ? 13'(int'(a) * 32 + nid / 8) : 13'd0;
            chk($sformatf("%s_mem%0d", tag, k),
                mk(1'b1, !rd, ad, is_ev, md == MD_TREF, vs, syn, sa, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        @(negedge CLK);
        chk($sformatf("%s_done", tag),
            mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, vs, 1'b0, 13'd0, md != MD_SPI,
               md == MD_SPI, md == MD_TREF, is_ev));
        for (int j = 0; j < hold; j++) begin
            @(negedge CLK);
            chk($sformatf("%s_hold%0d", tag, j),
                mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, vs, 1'b0, 13'd0, 1'b0,
                   md == MD_SPI, md == MD_TREF, is_ev));
        end
        if (md == MD_SPI)       bus.SPI_REQ  = 1'b0;
        else if (md == MD_TREF) bus.TREF_REQ = 1'b0;
        else                    bus.EVT_REQ  = 1'b0;
        @(negedge CLK);
        chk($sformatf("%s_release", tag), '0);
    endtask

    logic [7:0] ra;
    logic [4:0] rv;
    logic       rw;

    initial begin
        checks                 = 0;
        failures               = 0;
        RST_sync               = 1'b1;
        SPI_GATE_ACTIVITY_sync = 1'b0;
        bus.SPI_REQ            = 1'b0;
        bus.SPI_WE             = 1'b0;
        bus.SPI_ADDR           = 8'd0;
        bus.TREF_REQ           = 1'b0;
        bus.EVT_REQ            = 1'b0;
        bus.EVT_ADDR           = 8'd0;
        bus.EVT_VIRT           = 5'd0;

        idle_check("reset", 3);
        RST_sync = 1'b0;
        idle_check("post_reset", 2);

        // Directed real event on pre-synaptic neuron 0x05
        bus.EVT_ADDR = 8'h05;
        bus.EVT_VIRT = 5'd0;
        bus.EVT_REQ  = 1'b1;
        expect_op(MD_EVT, 8'h05, 5'd0, 1'b0, 3, -1, "evt05");

        // Random real events
        for (int i = 0; i < 2; i++) begin
            ra = 8'($urandom);
            bus.EVT_ADDR = ra;
            bus.EVT_VIRT = 5'd0;
            bus.EVT_REQ  = 1'b1;
            expect_op(MD_EVT, ra, 5'd0, 1'b0, int'($urandom_range(0, 3)), -1, $sformatf("evt_r%0d", i));
        end

        // Simultaneous TREF and EVT: tref sweep first, event sweep right after
        ra = 8'($urandom);
        bus.EVT_ADDR = ra;
        bus.EVT_VIRT = 5'd0;
        bus.TREF_REQ = 1'b1;
        bus.EVT_REQ  = 1'b1;
        expect_op(MD_TREF, 8'd0, 5'd0, 1'b0, 1, -1, "tref_first");
        expect_op(MD_EVT, ra, 5'd0, 1'b0, 0, -1, "evt_after_tref");

        // Directed virtual event, then random ones
        bus.EVT_ADDR = 8'h3C;
        bus.EVT_VIRT = 5'b10110;
        bus.EVT_REQ  = 1'b1;
        expect_op(MD_VIRT, 8'h3C, 5'b10110, 1'b0, 2, -1, "virt3c");
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom);
            rv = 5'($urandom_range(1, 31));
            bus.EVT_ADDR = ra;
            bus.EVT_VIRT = rv;
            bus.EVT_REQ  = 1'b1;
            expect_op(MD_VIRT, ra, rv, 1'b0, int'($urandom_range(0, 3)), -1, $sformatf("virt_r%0d", i));
        end
        bus.EVT_VIRT = 5'd0;

        // Gated: only the SPI write runs, the pending event waits for the gate to drop
        SPI_GATE_ACTIVITY_sync = 1'b1;
        bus.SPI_WE   = 1'b1;
        bus.SPI_ADDR = 8'h10;
        bus.SPI_REQ  = 1'b1;
        bus.EVT_ADDR = 8'h21;
        bus.EVT_REQ  = 1'b1;
        expect_op(MD_SPI, 8'h10, 5'd0, 1'b1, 1, -1, "spi_wr10");
        idle_check("gated_evt_pending", 4);
        SPI_GATE_ACTIVITY_sync = 1'b0;
        expect_op(MD_EVT, 8'h21, 5'd0, 1'b0, 0, -1, "evt_after_gate");

        // SPI request without the gate is never served
        bus.SPI_REQ = 1'b1;
        idle_check("spi_ungated", 10);
        bus.SPI_REQ = 1'b0;
        idle_check("spi_ungated_drop", 1);

        // SPI read of 0xFF, then random SPI accesses
        SPI_GATE_ACTIVITY_sync = 1'b1;
        bus.SPI_WE   = 1'b0;
        bus.SPI_ADDR = 8'hFF;
        bus.SPI_REQ  = 1'b1;
        expect_op(MD_SPI, 8'hFF, 5'd0, 1'b0, 2, -1, "spi_rdff");
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom);
            rw = 1'($urandom);
            bus.SPI_WE   = rw;
            bus.SPI_ADDR = ra;
            bus.SPI_REQ  = 1'b1;
            expect_op(MD_SPI, ra, 5'd0, rw, int'($urandom_range(0, 2)), -1, $sformatf("spi_r%0d", i));
        end
        SPI_GATE_ACTIVITY_sync = 1'b0;

        // Reset while the sweep is reading neuron 100; the held request restarts at neuron 0
        ra = 8'($urandom);
        bus.EVT_ADDR = ra;
        bus.EVT_VIRT = 5'd0;
        bus.EVT_REQ  = 1'b1;
        expect_op(MD_EVT, ra, 5'd0, 1'b0, 0, 201, "evt_pre_rst");
        RST_sync = 1'b1;
        idle_check("rst_mid_sweep", 1);
        RST_sync = 1'b0;
        expect_op(MD_EVT, ra, 5'd0, 1'b0, 1, -1, "evt_restart");

        idle_check("final_idle", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_update_sequencer.md
Name: neuron_update_sequencer

Overview:
Controller that sequences the neuron core's 256x128 neuron state memory and the synapse array. It arbitrates three requesters onto the single-port neuron memory:
- SPI configuration access
- time-reference (leak) sweeps
- AER spike events, real or virtual

For each neuron it drives a read-then-write slot (read-modify-write) and produces the CTRL_* control inputs of neuron_core.

Parameters:
N, 256, number of neurons; power of 2, sweep length.
M, 8, log2(N); neuron address width.

Ports:
CLK  in  1  system clock.
RST_sync  in  1  synchronous active-high reset.
SPI_GATE_ACTIVITY_sync  in  1  1 = network frozen; only SPI is served.
SPI_REQ  in  1  SPI access request, 4-phase.
SPI_WE  in  1  1 = masked write, 0 = read.
SPI_ADDR  in  M  neuron to access.
SPI_ACK  out  1  SPI handshake ack.
TREF_REQ  in  1  time-reference sweep request, 4-phase.
TREF_ACK  out  1  tref ack.
EVT_REQ  in  1  AER event request, 4-phase.
EVT_ADDR  in  M  pre-synaptic neuron (real event) or target neuron (virtual event).
EVT_VIRT  in  5  virtual event code; 0 = real synaptic event.
EVT_ACK  out  1  event ack.
CTRL_NEURMEM_CS  out  1  neuron memory chip select.
CTRL_NEURMEM_WE  out  1  neuron memory write enable.
CTRL_NEURMEM_ADDR  out  M  neuron memory address.
CTRL_NEUR_EVENT  out  1  synaptic or virtual event update in progress.
CTRL_NEUR_TREF  out  1  time-reference update in progress.
CTRL_NEUR_VIRTS  out  5  latched virtual event code.
CTRL_SYNARRAY_CS  out  1  synapse array read.
CTRL_SYNARRAY_ADDR  out  2M-3  synapse word address.
CTRL_NEUR_BURST_END  out  1  one-cycle pulse at the end of each event or tref operation.

Behaviour:
- All outputs are registered. On RST_sync (any state, including mid-sweep):
  - state = IDLE, sweep counter = 0
  - every output = 0
  - latched EVT_ADDR/EVT_VIRT cleared
  - no ack is issued for the aborted operation.
- States: IDLE, RD, WR, DONE. A mode register (SPI/TREF/EVT/VIRT) is captured at grant.
- Arbitration: only in IDLE; fixed priority SPI > TREF > EVT; no preemption.
  - SPI_GATE_ACTIVITY_sync = 1: only SPI_REQ is grantable; TREF/EVT requests are held pending.
  - SPI_GATE_ACTIVITY_sync = 0: SPI_REQ is ignored (held pending).
- Grant in cycle t:
  - latch mode, EVT_ADDR/EVT_VIRT or SPI_ADDR, counter = 0.
  - state = RD at t+1.
- RD: CS=1, WE=0, ADDR = counter (TREF, real EVT) or the latched address (SPI, VIRT).
- WR (cycle after RD): CS=1, WE=1, same ADDR.
- Sequencing per mode:
  - Real EVT and TREF: sweep neurons 0..N-1, RD/WR pairs, counter increments after each WR. CS is active for exactly 2N cycles. After the WR of neuron N-1, go to DONE.
  - VIRT: a single RD/WR pair on EVT_ADDR, then DONE.
  - SPI write: a single RD/WR pair on SPI_ADDR, then DONE.
  - SPI read: RD only, then DONE. NEUR_STATE is valid from the DONE cycle onward because the memory output holds while CS=0.
- Mode outputs:
  - CTRL_NEUR_EVENT = 1 in RD and WR of EVT/VIRT modes.
  - CTRL_NEUR_TREF = 1 in RD and WR of TREF mode.
  - CTRL_NEUR_VIRTS = latched EVT_VIRT in VIRT mode, 0 otherwise.
- Synapse array (real EVT only): in each RD cycle, CTRL_SYNARRAY_CS = 1 and CTRL_SYNARRAY_ADDR = {EVT_ADDR_latched, counter[M-1:3]}. Synapse data thus lands in the WR cycle, aligned with NEUR_STATE.
- DONE:
  - the ack of the served requester = 1, held while its REQ stays high (4-phase).
  - CTRL_NEUR_BURST_END = 1 in the first DONE cycle only, for EVT/TREF/VIRT modes, never for SPI.
  - return to IDLE in the cycle after REQ is seen low; ack = 0 in that cycle.
  - Requests arriving meanwhile stay pending.
- Latency:
  - real EVT/TREF: grant → first DONE cycle = 2N+1 cycles.
  - VIRT / SPI write: 3 cycles.
  - SPI read: 2 cycles.
- Counter wraps to 0 only through the DONE path, never mid-sweep.
- A REQ that drops before its ack is a protocol violation; the sequencer still completes the operation and enters DONE.

Decomposition:
- Shared package: state encoding (IDLE/RD/WR/DONE), mode encoding (MODE_SPI/TREF/EVT/VIRT), constants N, M, and the synapse-address width 2M-3.
- One sub-module, neuron_update_arbiter: combinational fixed-priority grant with the SPI gate qualification.
- Sweep counter and FSM stay in the top module.

Test Plan:
- Real event: EVT_REQ, EVT_ADDR=8'h05, EVT_VIRT=0, gate=0 → 512 CS cycles alternating WE 0/1, ADDR 0..255, SYNARRAY_ADDR 13'h0A0..13'h0BF each repeated 8 times. BURST_END pulse and EVT_ACK at cycle 513 after grant; ACK holds until REQ drops.
- TREF_REQ and EVT_REQ in the same cycle → TREF sweep first (TREF=1, EVENT=0), then the EVT sweep; 2 BURST_END pulses total.
- Virtual event: EVT_VIRT=5'b10110, EVT_ADDR=8'h3C → one RD/WR pair at address 0x3C, VIRTS=5'b10110 during both cycles, SYNARRAY_CS stays 0, ack at cycle 3.
- Gating: gate=1, SPI_REQ with SPI_WE=1, SPI_ADDR=8'h10, plus pending EVT_REQ → only the SPI RD/WR on 0x10 runs, no BURST_END. After gate drops, the EVT sweep starts. SPI_REQ with gate=0 → never acked.
- RST_sync asserted mid-sweep at counter 100 → next cycle all outputs 0, state IDLE, no ack. After release, a held EVT_REQ restarts the sweep at address 0.
- SPI read on 8'hFF → single RD with CS=1, WE=0, SPI_ACK 2 cycles after grant, no WE pulse at all.
